// File: rtl/maindec_pipe_pkg.sv
// maindec_pipe_pkg: MIPS op/funct/rt codes, control-word bit indices and decode classes.
package maindec_pipe_pkg;

    localparam int CW_W        = 15;
    localparam int CW_MEMTOREG = 14;
    localparam int CW_MEMEN    = 13;
    localparam int CW_MEMWRITE = 12;
    localparam int CW_BRANCH   = 11;
    localparam int CW_ALUSRC   = 10;
    localparam int CW_REGDST   = 9;
    localparam int CW_REGWRITE = 8;
    localparam int CW_HILOWR   = 7;
    localparam int CW_JUMP     = 6;
    localparam int CW_JAL      = 5;
    localparam int CW_JR       = 4;
    localparam int CW_BAL      = 3;
    localparam int CW_MULDIV   = 2;
    localparam int CW_MDSIGN   = 1;
    localparam int CW_RI       = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        CLS_RI, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BR, CLS_BAL, CLS_J,
        CLS_JAL, CLS_JR, CLS_JALR, CLS_ALUR, CLS_MFHL, CLS_MTHL, CLS_MULDIV
    } dec_cls_e;

    function automatic logic [CW_W-1:0] cls_cw(input dec_cls_e c);
        logic [CW_W-1:0] w;
        w = '0;
        case (c)
            CLS_ALUI:   begin w[CW_ALUSRC] = 1'b1; w[CW_REGWRITE] = 1'b1; end
            CLS_LOAD:   begin w[CW_MEMTOREG] = 1'b1; w[CW_MEMEN] = 1'b1; w[CW_ALUSRC] = 1'b1; w[CW_REGWRITE] = 1'b1; end
            CLS_STORE:  begin w[CW_MEMEN] = 1'b1; w[CW_MEMWRITE] = 1'b1; w[CW_ALUSRC] = 1'b1; end
            CLS_BR:     w[CW_BRANCH] = 1'b1;
            CLS_BAL:    begin w[CW_BRANCH] = 1'b1; w[CW_REGWRITE] = 1'b1; w[CW_BAL] = 1'b1; end
            CLS_J:      w[CW_JUMP] = 1'b1;
            CLS_JAL:    begin w[CW_REGWRITE] = 1'b1; w[CW_JUMP] = 1'b1; w[CW_JAL] = 1'b1; end
            CLS_JR:     w[CW_JR] = 1'b1;
            CLS_JALR:   begin w[CW_REGDST] = 1'b1; w[CW_REGWRITE] = 1'b1; w[CW_JR] = 1'b1; end
            CLS_ALUR,
            CLS_MFHL:   begin w[CW_REGDST] = 1'b1; w[CW_REGWRITE] = 1'b1; end
            CLS_MTHL:   begin w[CW_REGDST] = 1'b1; w[CW_HILOWR] = 1'b1; end
            CLS_MULDIV: begin w[CW_HILOWR] = 1'b1; w[CW_MULDIV] = 1'b1; end
            default:    w[CW_RI] = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/maindec_cw.sv
// maindec_cw: combinational instruction-field decode to control word and hilo-class flag.
module maindec_cw
    import maindec_pipe_pkg::*;
(
    input  logic [5:0]      op_i,
    input  logic [4:0]      rt_i,
    input  logic [5:0]      fn_i,
    output logic [CW_W-1:0] cw_o,
    output logic            is_hilo_o
);

    dec_cls_e cls;

    always_comb begin
        cls = CLS_RI;
        case (op_i)
            OP_SPECIAL: case (fn_i)
                FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                FN_XOR, FN_NOR, FN_SLT, FN_SLTU:         cls = CLS_ALUR;
                FN_MFHI, FN_MFLO:                        cls = CLS_MFHL;
                FN_MTHI, FN_MTLO:                        cls = CLS_MTHL;
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:      cls = CLS_MULDIV;
                FN_JR:                                   cls = CLS_JR;
                FN_JALR:                                 cls = CLS_JALR;
                default:                                 cls = CLS_RI;
            endcase
            OP_REGIMM: cls = (rt_i == RT_BLTZ || rt_i == RT_BGEZ) ? CLS_BR :
                             (rt_i == RT_BLTZAL || rt_i == RT_BGEZAL) ? CLS_BAL : CLS_RI;
            OP_J:                                        cls = CLS_J;
            OP_JAL:                                      cls = CLS_JAL;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:            cls = CLS_BR;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:            cls = CLS_ALUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:         cls = CLS_LOAD;
            OP_SB, OP_SH, OP_SW:                         cls = CLS_STORE;
            default:                                     cls = CLS_RI;
        endcase
    end

    // The signed forms (MULT, DIV) are the even functs of the mul/div group.
    assign cw_o      = cls_cw(cls) | (CW_W'(cls == CLS_MULDIV && !fn_i[0]) << CW_MDSIGN);
    assign is_hilo_o = cls inside {CLS_MFHL, CLS_MTHL, CLS_MULDIV};

endmodule

// File: rtl/maindec_pipe.sv
// maindec_pipe: registered main-decode stage with valid/ready handshake and HI/LO busy interlock.
module maindec_pipe
    import maindec_pipe_pkg::*;
#(
    parameter  int MUL_CYCLES = 1,
    parameter  int DIV_CYCLES = 32,
    localparam int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    output logic            instr_ready_o,
    input  logic            flush_i,
    output logic            cw_valid_o,
    input  logic            out_ready_i,
    output logic [CW_W-1:0] cw_o,
    output logic [31:0]     instr_q_o,
    output logic            hilo_busy_o
);

    logic [CW_W-1:0]  dec_cw, cw_q, cw_d;
    logic             dec_is_hilo;
    logic [31:0]      instr_q, instr_d;
    logic             cw_valid_q, cw_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer, hazard, accept, load;

    maindec_cw u_dec (
        .op_i      (instr_i[31:26]),
        .rt_i      (instr_i[20:16]),
        .fn_i      (instr_i[5:0]),
        .cw_o      (dec_cw),
        .is_hilo_o (dec_is_hilo)
    );

    assign xfer          = cw_valid_q & out_ready_i;
    assign hazard        = (cnt_q != '0) | (xfer & cw_q[CW_MULDIV]);
    assign instr_ready_o = (~cw_valid_q | out_ready_i) & ~(hazard & dec_is_hilo);
    assign accept        = instr_valid_i & instr_ready_o;
    assign load          = accept & ~flush_i;

    // instr_q[1] separates DIV/DIVU (0x1A/0x1B) from MULT/MULTU (0x18/0x19).
    always_comb begin
        cw_valid_d = flush_i ? 1'b0 : accept ? 1'b1 : xfer ? 1'b0 : cw_valid_q;
        cw_d       = load ? dec_cw : cw_q;
        instr_d    = load ? instr_i : instr_q;
        cnt_d      = (xfer && cw_q[CW_MULDIV]) ? (instr_q[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES)) :
                     (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cw_valid_q <= 1'b0;
            cw_q       <= '0;
            instr_q    <= '0;
            cnt_q      <= '0;
        end else begin
            cw_valid_q <= cw_valid_d;
            cw_q       <= cw_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cw_valid_o  = cw_valid_q;
    assign cw_o        = cw_q;
    assign instr_q_o   = instr_q;
    assign hilo_busy_o = cnt_q != '0;

endmodule

// File: tb/tb_maindec_pipe.sv
// tb_maindec_pipe: decode table, handshake/interlock sequences and a randomized run against a reference model.
module tb_maindec_pipe;

    localparam int MUL = 3;
    localparam int DIV = 32;

    localparam logic [31:0] I_ADDIU = 32'h24010005, I_LW   = 32'h8FA80004, I_MULT = 32'h00850018;
    localparam logic [31:0] I_MFLO  = 32'h00001012, I_DIV  = 32'h0085001A, I_MFHI = 32'h00001010;
    localparam logic [31:0] I_ADDI2 = 32'h2402ABCD;

    logic        clk = 1'b0, resetn = 1'b0, instr_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready, cw_valid, hilo_busy;
    logic [14:0] cw;
    logic [31:0] instr_q;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    maindec_pipe #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_ready_o (instr_ready),
        .flush_i       (flush),
        .cw_valid_o    (cw_valid),
        .out_ready_i   (out_ready),
        .cw_o          (cw),
        .instr_q_o     (instr_q),
        .hilo_busy_o   (hilo_busy)
    );

    typedef struct {
        logic [31:0] w;
        logic [14:0] cw;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic ory, input logic fl);
        instr_valid = v;
        instr       = w;
        out_ready   = ory;
        flush       = fl;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick;
        tick;
        resetn = 1'b1;
        #1;
    endtask

    task automatic wait_idle;
        int g;
        g = 0;
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        while ((hilo_busy || cw_valid) && g < 100) begin
            tick;
            g++;
        end
        chk("idle_timeout", 32'(g < 100), 32'd1);
    endtask

    // Reference decode: the 12-bit control patterns written per instruction group, then {muldiv, mdsign, ri}.
    function automatic logic [14:0] ref_cw(input logic [31:0] w);
        logic [5:0]  op, fn;
        logic [4:0]  rt;
        logic [11:0] p;
        logic        md, sg, ri;
        op = w[31:26]; rt = w[20:16]; fn = w[5:0];
        p = '0; md = 1'b0; sg = 1'b0; ri = 1'b0;
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, [6'h20:6'h27], 6'h2A, 6'h2B})
                p = 12'b000001100000;
            else if (fn == 6'h08) p = 12'b000000000010;
            else if (fn == 6'h09) p = 12'b000001100010;
            else if (fn inside {6'h11, 6'h13}) p = 12'b000001010000;
            else if (fn inside {[6'h18:6'h1B]}) begin
                p = 12'b000000010000; md = 1'b1; sg = (fn == 6'h18 || fn == 6'h1A);
            end else ri = 1'b1;
        end else if (op == 6'h01) begin
            if (rt inside {5'h00, 5'h01}) p = 12'b000100000000;
            else if (rt inside {5'h10, 5'h11}) p = 12'b000100100001;
            else ri = 1'b1;
        end
        else if (op inside {[6'h04:6'h07]}) p = 12'b000100000000;
        else if (op inside {[6'h08:6'h0F]}) p = 12'b000010100000;
        else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) p = 12'b110010100000;
        else if (op inside {6'h28, 6'h29, 6'h2B}) p = 12'b011010000000;
        else if (op == 6'h02) p = 12'b000000001000;
        else if (op == 6'h03) p = 12'b000000101100;
        else ri = 1'b1;
        return {p, md, sg, ri};
    endfunction

    function automatic logic ref_hilo(input logic [31:0] w);
        return w[31:26] == 6'h00 && (w[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]});
    endfunction

    vec_t        tbl[$];
    logic [31:0] pool[$];

    initial begin
        int          g, held, busy_n;
        logic        m_v, e_rdy, e_hz;
        logic [14:0] m_cw;
        logic [31:0] m_iq, w;
        int          cyc, free_at;

        tbl.push_back('{32'h24010005, 15'h0500});
        tbl.push_back('{32'h8FA80004, 15'h6500});
        tbl.push_back('{32'hAFA80004, 15'h3400});
        tbl.push_back('{32'h10850003, 15'h0800});
        tbl.push_back('{32'h04000004, 15'h0800});
        tbl.push_back('{32'h04100004, 15'h0908});
        tbl.push_back('{32'h04050000, 15'h0001});
        tbl.push_back('{32'h08000010, 15'h0040});
        tbl.push_back('{32'h0C000010, 15'h0160});
        tbl.push_back('{32'h03E00008, 15'h0010});
        tbl.push_back('{32'h0080F809, 15'h0310});
        tbl.push_back('{32'h00851020, 15'h0300});
        tbl.push_back('{32'h00000000, 15'h0300});
        tbl.push_back('{32'h3C000018, 15'h0500});
        tbl.push_back('{32'hFC000000, 15'h0001});
        tbl.push_back('{32'h0000003F, 15'h0001});
        tbl.push_back('{32'h00001012, 15'h0300});
        tbl.push_back('{32'h00800011, 15'h0280});
        tbl.push_back('{32'h00850018, 15'h0086});
        tbl.push_back('{32'h00850019, 15'h0084});
        tbl.push_back('{32'h0085001B, 15'h0084});

        do_reset;
        chk("rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("rst_cw", 32'(cw), 32'd0);
        chk("rst_instr_q", instr_q, 32'd0);
        chk("rst_hilo_busy", 32'(hilo_busy), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);

        drive(1'b1, I_ADDIU, 1'b1, 1'b0);
        tick;
        chk("addiu_valid", 32'(cw_valid), 32'd1);
        chk("addiu_cw", 32'(cw), 32'h0500);
        chk("addiu_iq", instr_q, I_ADDIU);
        drive(1'b1, I_LW, 1'b1, 1'b0);
        tick;
        chk("lw_cw", 32'(cw), 32'h6500);
        chk("lw_iq", instr_q, I_LW);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        chk("drain_valid", 32'(cw_valid), 32'd0);

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].w, 1'b1, 1'b0);
            #1;
            g = 0;
            while (!instr_ready && g < 100) begin
                tick;
                g++;
            end
            chk("tbl_wait", 32'(g < 100), 32'd1);
            tick;
            chk($sformatf("tbl_cw_%08h", tbl[i].w), 32'(cw), 32'(tbl[i].cw));
            chk($sformatf("tbl_iq_%08h", tbl[i].w), instr_q, tbl[i].w);
        end
        wait_idle;

        drive(1'b1, I_MULT, 1'b1, 1'b0);
        tick;
        drive(1'b1, I_MFLO, 1'b1, 1'b0);
        #1;
        held = 0;
        while (!instr_ready && held < 50) begin
            held++;
            tick;
        end
        chk("mflo_held_cycles", 32'(held), 32'(MUL + 1));
        tick;
        chk("mflo_cw", 32'(cw), 32'h0300);
        chk("mflo_iq", instr_q, I_MFLO);
        wait_idle;

        drive(1'b1, I_MULT, 1'b1, 1'b0);
        tick;
        drive(1'b1, I_ADDIU, 1'b1, 1'b0);
        #1;
        chk("addiu_unheld_ready", 32'(instr_ready), 32'd1);
        tick;
        chk("addiu_between_cw", 32'(cw), 32'h0500);
        drive(1'b1, I_MULT, 1'b1, 1'b0);
        #1;
        held = 0;
        while (!instr_ready && held < 50) begin
            held++;
            tick;
        end
        chk("mult_mult_held", 32'(held), 32'(MUL));
        tick;
        chk("mult2_iq", instr_q, I_MULT);
        wait_idle;

        drive(1'b1, I_DIV, 1'b1, 1'b0);
        tick;
        chk("div_muldiv", 32'(cw[2]), 32'd1);
        chk("div_mdsign", 32'(cw[1]), 32'd1);
        drive(1'b1, I_MFHI, 1'b1, 1'b0);
        #1;
        held = 0;
        busy_n = 0;
        while (!instr_ready && held < 100) begin
            held++;
            tick;
            if (hilo_busy) busy_n++;
        end
        chk("div_busy_cycles", 32'(busy_n), 32'(DIV));
        chk("mfhi_held_cycles", 32'(held), 32'(DIV + 1));
        wait_idle;

        drive(1'b1, I_ADDI2, 1'b1, 1'b0);
        tick;
        drive(1'b1, I_LW, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", 32'(cw_valid), 32'd1);
            chk("stall_cw", 32'(cw), 32'h0500);
            chk("stall_iq", instr_q, I_ADDI2);
            chk("stall_ready", 32'(instr_ready), 32'd0);
            tick;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        chk("release_xfer", 32'(cw_valid), 32'd0);
        tick;
        chk("release_single", 32'(cw_valid), 32'd0);

        drive(1'b1, I_ADDI2, 1'b1, 1'b0);
        tick;
        drive(1'b1, I_LW, 1'b0, 1'b1);
        tick;
        chk("flush_valid", 32'(cw_valid), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        chk("flush_dropped_valid", 32'(cw_valid), 32'd0);
        chk("flush_dropped_iq", instr_q, I_ADDI2);

        drive(1'b1, I_MULT, 1'b1, 1'b0);
        tick;
        drive(1'b0, '0, 1'b1, 1'b1);
        tick;
        chk("flush_xfer_busy", 32'(hilo_busy), 32'd1);
        chk("flush_xfer_valid", 32'(cw_valid), 32'd0);
        wait_idle;

        drive(1'b1, I_DIV, 1'b1, 1'b0);
        tick;
        drive(1'b1, I_MFHI, 1'b1, 1'b0);
        tick;
        tick;
        chk("middiv_busy", 32'(hilo_busy), 32'd1);
        resetn = 1'b0;
        tick;
        chk("middiv_rst_busy", 32'(hilo_busy), 32'd0);
        chk("middiv_rst_valid", 32'(cw_valid), 32'd0);
        resetn = 1'b1;
        tick;
        chk("middiv_release_valid", 32'(cw_valid), 32'd1);
        chk("middiv_release_iq", instr_q, I_MFHI);

        foreach (tbl[i]) pool.push_back(tbl[i].w);
        pool.push_back(I_MFHI);
        pool.push_back(32'h0085001A);
        do_reset;
        m_v = 1'b0; m_cw = '0; m_iq = '0; cyc = 0; free_at = 0;
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, pool.size() - 1)];
            drive($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
            #1;
            e_hz  = (cyc < free_at) || (m_v && out_ready && m_cw[2]);
            e_rdy = (!m_v || out_ready) && !(ref_hilo(w) && e_hz);
            chk("rnd_ready", 32'(instr_ready), 32'(e_rdy));
            chk("rnd_valid", 32'(cw_valid), 32'(m_v));
            chk("rnd_cw", 32'(cw), 32'(m_cw));
            chk("rnd_iq", instr_q, m_iq);
            chk("rnd_busy", 32'(hilo_busy), 32'(cyc < free_at));
            tick;
            cyc++;
            if (m_v && out_ready && m_cw[2]) free_at = cyc + ((m_iq[5:0] >= 6'h1A) ? DIV : MUL);
            if (flush) m_v = 1'b0;
            else if (instr_valid && e_rdy) begin
                m_v = 1'b1; m_cw = ref_cw(instr); m_iq = instr;
            end else if (m_v && out_ready) m_v = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
